// File: rtl/core_pkg.sv
// Shared core definitions: word widths, opcode map used by decode/immgen,
// and the fetch payload carried from the fetch FIFO to decode.
package core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef logic [ILEN-1:0] instr_t;

  // Major opcodes (instr[6:0]) shared with the decoder and immediate generator
  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    CALCI  = 7'b0010011,
    CALC   = 7'b0110011,
    FLOAD  = 7'b0000111,
    FSTORE = 7'b0100111,
    F      = 7'b1010011
  } opcode_t;

  typedef struct packed {
    instr_t            instr;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

  // Force an address onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small register FIFO holding fetched {instr, pc} entries for decode.
// Head entry is presented combinationally (no bypass from push to output).
// clear wins over push; push and pop together are allowed even when full.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  fetch_entry_t            wdata,
  output fetch_entry_t            rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  fetch_entry_t   mem_reg [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_W);
  assign count   = count_reg;
  assign rdata   = mem_reg[rd_ptr_reg];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Entry storage; reset to zero so the idle head reads as all-zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (do_push && !clear) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches to a
// pipelined instruction memory, buffers returned words and hands {instr, pc}
// to decode. Redirects flush buffered words and mark in-flight ones stale.
// Optional feature macro: FETCH_STATS_EN adds handshake/redirect counters.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_redirects
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_S = (AW+2)'(DEPTH);

  logic [31:0]   pc_reg;
  logic [AW:0]   outst_reg;
  logic [AW:0]   drop_reg;
  logic          running_reg;
  logic [31:0]   pcq_reg [DEPTH];
  logic [AW-1:0] pcq_wr_reg;
  logic [AW-1:0] pcq_rd_reg;

  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  fetch_entry_t  fifo_wdata;
  fetch_entry_t  fifo_rdata;
  logic [AW+1:0] credit_sum;
  logic          req_fire;
  logic          resp_keep;
  logic          pop_fire;

  // Buffered words plus outstanding requests may never exceed the FIFO size,
  // so every response always has a slot waiting for it.
  assign credit_sum     = {1'b0, fifo_count} + {1'b0, outst_reg};
  assign imem_req_valid = running_reg & ~redirect_valid & (credit_sum < DEPTH_S);
  assign imem_addr      = pc_reg;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign resp_keep      = imem_resp_valid & ~redirect_valid & (drop_reg == '0);
  assign pop_fire       = instr_valid & instr_ready;
  assign fifo_push      = resp_keep & (~fifo_full | pop_fire);
  assign fifo_wdata     = '{instr: imem_resp_data, pc: pcq_reg[pcq_rd_reg]};

  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_rdata.instr;
  assign instr_pc    = fifo_rdata.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (instr_ready),
    .clear (redirect_valid),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // PC, outstanding-request count, stale-response count and run enable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_reg      <= RESET_PC;
      outst_reg   <= '0;
      drop_reg    <= '0;
      running_reg <= 1'b0;
    end else begin
      running_reg <= 1'b1;
      outst_reg   <= outst_reg + (AW+1)'(req_fire) - (AW+1)'(imem_resp_valid);
      if (redirect_valid) begin
        pc_reg   <= word_align(redirect_pc);
        drop_reg <= outst_reg - (AW+1)'(imem_resp_valid);
      end else begin
        if (req_fire) pc_reg <= pc_reg + 32'd4;
        if (imem_resp_valid && drop_reg != '0) drop_reg <= drop_reg - (AW+1)'(1);
      end
    end
  end

  // Request-PC queue pointers; stale responses never consume an entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcq_wr_reg <= '0;
      pcq_rd_reg <= '0;
    end else if (redirect_valid) begin
      pcq_wr_reg <= '0;
      pcq_rd_reg <= '0;
    end else begin
      if (req_fire)  pcq_wr_reg <= pcq_wr_reg + AW'(1);
      if (resp_keep) pcq_rd_reg <= pcq_rd_reg + AW'(1);
    end
  end

  // Request-PC queue storage, written with the PC of each accepted request
  always_ff @(posedge clk) begin
    if (req_fire) pcq_reg[pcq_wr_reg] <= pc_reg;
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_reg;
  logic [31:0] stat_redirects_reg;

  // Wrapping event counters for decode handshakes and redirect cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_fetched_reg   <= '0;
      stat_redirects_reg <= '0;
    end else begin
      if (pop_fire)       stat_fetched_reg   <= stat_fetched_reg + 32'd1;
      if (redirect_valid) stat_redirects_reg <= stat_redirects_reg + 32'd1;
    end
  end

  assign stat_fetched   = stat_fetched_reg;
  assign stat_redirects = stat_redirects_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable memory responder,
// a scoreboard of expected {instr, pc} words and a model of the request PC.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_redirects;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched    (stat_fetched),
    .stat_redirects  (stat_redirects)
`endif
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;

  mreq_t       pend_q[$];
  exp_t        exp_q[$];
  logic [31:0] fire_log[$];
  logic [31:0] pop_log[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cycle_cnt = 0;
  int          mem_lat = 1;
  int          pops = 0;
  bit          running_m = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] m_fetched = 32'h0;
  logic [31:0] m_redirects = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'd3 + 32'h1357_9BDF;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (pend_q[i]) if (!pend_q[i].stale) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, check outputs, advance models.
  task automatic cyc();
    bit   resp_now;
    bit   fire;
    bit   pop;
    int   live;
    int   stale;
    exp_t e;
    resp_now = (pend_q.size() > 0) && (pend_q[0].due <= cycle_cnt);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? mem_word(pend_q[0].addr) : 32'h0;
    #1;
    live  = live_cnt();
    stale = pend_q.size() - live;
    chk("req_valid", 32'(imem_req_valid),
        32'(running_m && !redirect_valid && ((exp_q.size() + stale) < DEPTH)));
    chk("instr_valid", 32'(instr_valid), 32'((exp_q.size() - live) > 0));
    if ((exp_q.size() - live) > 0) begin
      chk("instr", instr, exp_q[0].instr);
      chk("instr_pc", instr_pc, exp_q[0].pc);
    end
`ifdef FETCH_STATS_EN
    chk("stat_fetched", stat_fetched, m_fetched);
    chk("stat_redirects", stat_redirects, m_redirects);
`endif
    fire = imem_req_valid && imem_req_ready;
    pop  = instr_valid && instr_ready;
    if (fire) chk("imem_addr", imem_addr, exp_pc);
    @(posedge clk);
    if (pop) begin
      $display("pop  pc=%h instr=%h", instr_pc, instr);
      pops++;
      m_fetched = m_fetched + 32'd1;
      pop_log.push_back(instr_pc);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (resp_now) void'(pend_q.pop_front());
    if (redirect_valid) begin
      exp_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_pc = {redirect_pc[31:2], 2'b00};
      m_redirects = m_redirects + 32'd1;
      fire_log.delete();
      pop_log.delete();
    end
    if (fire) begin
      fire_log.push_back(imem_addr);
      e.instr = mem_word(exp_pc);
      e.pc    = exp_pc;
      exp_q.push_back(e);
      pend_q.push_back('{addr: imem_addr, due: cycle_cnt + mem_lat, stale: 1'b0});
      exp_pc = exp_pc + 32'd4;
    end
    running_m = 1'b1;
    cycle_cnt++;
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int p0;
    bit hit;
    // Reset state
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Streaming with 1-cycle memory and decode always ready
    mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1; pops = 0;
    repeat (20) cyc();
    chk("stream_throughput", 32'(pops), 32'd17);
    chk("stream_addr0", (fire_log.size() > 0) ? fire_log[0] : 32'hDEAD_BEEF, 32'h0);
    chk("stream_addr1", (fire_log.size() > 1) ? fire_log[1] : 32'hDEAD_BEEF, 32'h4);
    chk("stream_addr2", (fire_log.size() > 2) ? fire_log[2] : 32'hDEAD_BEEF, 32'h8);
    chk("stream_pc0", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0);

    // Random memory and decode backpressure
    repeat (16) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      instr_ready    = 1'($urandom_range(0, 1));
      cyc();
    end

    // Decode stalled for 10 cycles, then released
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    repeat (10) cyc();
    chk("stall_credit_block", 32'(imem_req_valid), 32'h0);
    instr_ready = 1'b1;
    p0 = pops;
    repeat (8) cyc();
    chk("stall_release_pops", 32'(pops - p0), 32'd8);

    // Redirect with three requests in flight
    mem_lat = 3;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (pend_q.size() >= 3) hit = 1'b1;
      else cyc();
    end
    chk("inflight_reached", 32'(hit), 32'h1);
    chk("inflight_count", 32'(pend_q.size()), 32'd3);
    do_redirect(32'h0000_1003);
    mem_lat = 1;
    repeat (12) cyc();
    chk("redir_addr", (fire_log.size() > 0) ? fire_log[0] : 32'hDEAD_BEEF, 32'h0000_1000);
    chk("redir_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_1000);

    // Redirect coinciding with a response and a decode pop
    mem_lat = 2;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (pend_q.size() > 0 && pend_q[0].due <= cycle_cnt && (exp_q.size() - live_cnt()) > 0)
        hit = 1'b1;
      else cyc();
    end
    chk("coincide_reached", 32'(hit), 32'h1);
    p0 = pops;
    do_redirect(32'h0000_2000);
    chk("coincide_pop", 32'(pops - p0), 32'd1);
    repeat (10) cyc();
    chk("coincide_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_2000);

    // Back-to-back redirects: last target wins
    do_redirect(32'h0000_3000);
    do_redirect(32'h0000_4006);
    repeat (10) cyc();
    chk("b2b_addr", (fire_log.size() > 0) ? fire_log[0] : 32'hDEAD_BEEF, 32'h0000_4004);
    chk("b2b_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_4004);

    // PC wrap
    mem_lat = 1;
    do_redirect(32'hFFFF_FFF8);
    repeat (10) cyc();
    chk("wrap_addr0", (fire_log.size() > 0) ? fire_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    chk("wrap_addr1", (fire_log.size() > 1) ? fire_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_addr2", (fire_log.size() > 2) ? fire_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Fill the FIFO, then pull reset mid-cycle
    instr_ready = 1'b0;
    repeat (8) cyc();
    chk("full_before_rst", 32'(instr_valid), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_req_valid", 32'(imem_req_valid), 32'h0);
    chk("async_instr_valid", 32'(instr_valid), 32'h0);
    chk("async_instr", instr, 32'h0);
    chk("async_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_STATS_EN
    chk("async_stat_fetched", stat_fetched, 32'h0);
    chk("async_stat_redirects", stat_redirects, 32'h0);
`endif
    pend_q.delete(); exp_q.delete(); fire_log.delete(); pop_log.delete();
    exp_pc = RESET_PC; running_m = 1'b0; m_fetched = 32'h0; m_redirects = 32'h0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    instr_ready = 1'b1;
    repeat (12) cyc();
    chk("restart_addr", (fire_log.size() > 0) ? fire_log[0] : 32'hDEAD_BEEF, RESET_PC);
    chk("restart_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
